bit_serial_alu_ctrl: RTL and testbench

Initiator that drives the team's combinational 1-bit ALU slice (3-bit opcode in; o1 result / o2 carry-or-borrow out) to perform WIDTH-bit operations bit-serially, LSB first. It accepts a command via a start/ready handshake and latches the operands. It sequences one bit per clock through the slice and chains carry or borrow locally. It returns a registered WIDTH-bit result plus flag. It sits between the datapath controller and the 1-bit slice.

---
 rtl/bit_serial_alu_ctrl.sv | 129 ++++++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial initiator for the 1-bit ALU slice: latches a command, walks the
// operands LSB first through the slice, chains carry/borrow and returns a
// registered WIDTH-bit result with carry/borrow flag.
module bit_serial_alu_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             alu_a,
  output logic             alu_b,
  output logic [2:0]       alu_oc,
  input  logic             alu_o1,
  input  logic             alu_o2
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_sh, b_sh, acc;
  logic [2:0]        op;
  logic              c, c_nxt, bit_out;
  logic [CW-1:0]     cnt;
  logic              op_valid, last_bit;

  assign op_valid = !(opcode[2] && opcode[1]);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Slice gives half-adder/half-subtractor terms; the chain bit completes them.
  always_comb begin
    bit_out = alu_o1;
    c_nxt   = 1'b0;
    case (op)
      OP_ADD: begin
        bit_out = alu_o1 ^ c;
        c_nxt   = alu_o2 | (alu_o1 & c);
      end
      OP_SUB: begin
        bit_out = alu_o1 ^ c;
        c_nxt   = alu_o2 | (~alu_o1 & c);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    alu_a     = 1'b0;
    alu_b     = 1'b0;
    alu_oc    = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start && op_valid) state_nxt = RUN;
      end
      RUN: begin
        alu_a  = a_sh[0];
        alu_b  = b_sh[0];
        alu_oc = op;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result is loaded on the final RUN edge so it is valid in the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      op     <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      err    <= 1'b0;
      result <= '0;
      flag   <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && !op_valid;
      case (state)
        IDLE: begin
          if (start && op_valid) begin
            a_sh <= a_in;
            b_sh <= b_in;
            op   <= opcode;
            c    <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          acc  <= {bit_out, acc[WIDTH-1:1]};
          c    <= c_nxt;
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            result <= {bit_out, acc[WIDTH-1:1]};
            flag   <= c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Scoreboard bench for bit_serial_alu_ctrl with a behavioural 1-bit ALU slice.
module tb_bit_serial_alu_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   opcode;
  logic [W-1:0] a_in, b_in;
  logic         ready, done, err, flag;
  logic [W-1:0] result;
  logic         alu_a, alu_b, alu_o1, alu_o2;
  logic [2:0]   alu_oc;

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .a_in(a_in), .b_in(b_in), .ready(ready), .done(done), .err(err),
    .result(result), .flag(flag), .alu_a(alu_a), .alu_b(alu_b),
    .alu_oc(alu_oc), .alu_o1(alu_o1), .alu_o2(alu_o2)
  );

  always #5 clk = ~clk;

  // 1-bit slice: o1 is the bit result, o2 the local carry (ADD) or borrow (SUB).
  always_comb begin
    alu_o1 = 1'b0;
    alu_o2 = 1'b0;
    case (alu_oc)
      3'b000: begin alu_o1 = alu_a ^ alu_b; alu_o2 = alu_a & alu_b;  end
      3'b001: begin alu_o1 = alu_a ^ alu_b; alu_o2 = ~alu_a & alu_b; end
      3'b010, 3'b100: alu_o1 = alu_a & alu_b;
      3'b011: alu_o1 = alu_a | alu_b;
      3'b101: alu_o1 = alu_a ^ alu_b;
      default: ;
    endcase
  end

  typedef struct {
    logic         is_err;
    logic [W-1:0] res;
    logic         flg;
    int           when;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;
  int           next_ready_cyc = 0;
  logic [W-1:0] last_res = '0;
  logic         last_flg = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    int unsigned ua, ub;
    ua = a;
    ub = b;
    case (op)
      3'b000: return (W+1)'(ua + ub);
      3'b001: return {ua < ub, W'(ua - ub)};
      3'b010, 3'b100: return {1'b0, a & b};
      3'b011: return {1'b0, a | b};
      3'b101: return {1'b0, a ^ b};
      default: return '0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b with nothing outstanding (cycle %0d)",
                 done, err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("err_pulse", err, e.is_err);
        chk("done_pulse", done, !e.is_err);
        chk("pulse_cycle", cyc, e.when);
        chk("result", result, e.res);
        chk("flag", flag, e.flg);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", ready, 1'b1);
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input int poke_at, input int abort_at);
    int   k;
    exp_t e;
    logic [W:0] m;
    wait_ready();
    if (!ready) return;
    chk("ready_time", cyc, next_ready_cyc);
    start  = 1'b1;
    opcode = op;
    a_in   = a;
    b_in   = b;
    k      = cyc;
    if (op[2] && op[1]) begin
      e = '{is_err: 1'b1, res: last_res, flg: last_flg, when: k + 1};
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("ready_on_err", ready, 1'b1);
      next_ready_cyc = cyc;
      return;
    end
    m = model(op, a, b);
    e = '{is_err: 1'b0, res: m[W-1:0], flg: m[W], when: k + W + 1};
    sb.push_back(e);
    last_res = m[W-1:0];
    last_flg = m[W];
    next_ready_cyc = k + W + 2;
    for (int j = 0; j < W; j++) begin
      @(negedge clk);
      start = (j == poke_at);
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      if (j == poke_at) opcode = 3'($urandom_range(0, 5));
      chk("run_alu_oc", alu_oc, op);
      chk("run_alu_a", alu_a, a[j]);
      chk("run_alu_b", alu_b, b[j]);
      chk("run_ready", ready, 1'b0);
      if (j == abort_at) begin
        start = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_flag", flag, 1'b0);
        chk("rst_alu", {alu_a, alu_b, alu_oc}, '0);
        void'(sb.pop_back());
        last_res = '0;
        last_flg = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_ready_cyc = cyc;
        return;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    opcode = '0;
    a_in   = '0;
    b_in   = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", ready, 1'b1);
    chk("reset_done_err", {done, err}, 2'b00);
    chk("reset_result_flag", {result, flag}, '0);
    chk("reset_alu", {alu_a, alu_b, alu_oc}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    next_ready_cyc = cyc;

    send(3'b000, 8'hFF, 8'h01, -1, -1);
    send(3'b001, 8'h05, 8'h07, -1, -1);
    send(3'b001, 8'h07, 8'h05, -1, -1);
    send(3'b101, 8'hA5, 8'h3C, -1, -1);
    send(3'b011, 8'hA5, 8'h3C, -1, -1);
    send(3'b100, 8'hA5, 8'h3C, -1, -1);
    send(3'b010, 8'hA5, 8'h3C, -1, -1);
    send(3'b110, 8'h12, 8'h34, -1, -1);
    send(3'b111, 8'h56, 8'h78, -1, -1);
    send(3'b000, 8'h80, 8'h80, 3, -1);
    send(3'b000, 8'h0F, 8'h01, -1, 4);
    send(3'b000, 8'h0F, 8'h01, -1, -1);

    for (int i = 0; i < 60; i++) begin
      send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
           int'($urandom_range(0, 15)), -1);
    end

    for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
